// File: rtl/bad_shift_reg_pkg.sv
// bad_shift_reg_pkg: shared reset level and serial bit type for the shift-register demo blocks.
`default_nettype none
`timescale 1ns/1ps

package bad_shift_reg_pkg;

  localparam logic RST_ACTIVE = 1'b0;

  typedef logic serial_bit_t;

endpackage : bad_shift_reg_pkg

`default_nettype wire

// File: rtl/bad_shift_reg_if.sv
// bad_shift_reg_if: serial data line into and out of the register block.
`default_nettype none
`timescale 1ns/1ps

interface bad_shift_reg_if;
  import bad_shift_reg_pkg::*;

  serial_bit_t d;
  serial_bit_t dout;

  modport master (output d, input dout);
  modport slave  (input d, output dout);

endinterface : bad_shift_reg_if

`default_nettype wire

// File: rtl/bad_shift_reg.sv
//==============================================================================
// bad_shift_reg : two-stage shift chain with in-order stage updates, which
//                 collapses to a single-cycle delay (dout(n+1) = d(n)).
// Revision      : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module bad_shift_reg
  import bad_shift_reg_pkg::*;
(
  input  wire              clk,
  input  wire              reset,
  bad_shift_reg_if.slave   bus
);

  serial_bit_t q1_d;
  serial_bit_t q1_q;
  serial_bit_t dout_d;
  serial_bit_t dout_q;

  // The output stage sees the freshly captured q1, not last cycle's q1.
  always_comb begin
    q1_d   = bus.d;
    dout_d = q1_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACTIVE) begin
      q1_q   <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      q1_q   <= q1_d;
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;

`ifndef SYNTHESIS
  a_one_cycle_delay : assert property (
    @(posedge clk) disable iff (reset == RST_ACTIVE)
      $past(reset) |-> (dout_q == $past(bus.d))
  );

  a_stages_equal : assert property (
    @(posedge clk) disable iff (reset == RST_ACTIVE)
      q1_q == dout_q
  );

  a_clear_in_reset : assert property (
    @(posedge clk) (reset == RST_ACTIVE) |-> (dout_q == 1'b0)
  );
`endif

endmodule : bad_shift_reg

`default_nettype wire

// File: tb/tb_bad_shift_reg.sv
// tb_bad_shift_reg: directed checks of reset hold, one-cycle latency, async clear and random equivalence.
`default_nettype none
`timescale 1ns/1ps

module tb_bad_shift_reg;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic model_q;
  longint start_t;
  longint target_t;

  bad_shift_reg_if bus ();

  bad_shift_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.d = 1'b0;
    #0 reset = 1'b0;

    // Reset hold with d toggling (edges at 10..110 ns).
    #1 check("reset_initial", bus.dout, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #3 bus.d = ~bus.d;
      @(negedge clk);
      check("reset_hold", bus.dout, 1'b0);
    end
    #3;

    // Release 5 ns after an edge with d = 1.
    bus.d = 1'b1;
    @(posedge clk);
    #5 reset = 1'b1;
    #1 check("release_no_capture", bus.dout, 1'b0);
    @(negedge clk);
    check("release_before_edge", bus.dout, 1'b0);
    @(posedge clk);
    #1 check("release_first_edge", bus.dout, 1'b1);

    // Single-cycle latency: dout after each edge equals d driven before it.
    @(negedge clk) bus.d = 1'b1;
    @(posedge clk); #1 check("lat_edge_k", bus.dout, 1'b1);
    @(negedge clk) bus.d = 1'b0;
    @(posedge clk); #1 check("lat_edge_k1", bus.dout, 1'b0);
    @(negedge clk) bus.d = 1'b1;
    @(posedge clk); #1 check("lat_pulse_hi", bus.dout, 1'b1);
    @(negedge clk) bus.d = 1'b0;
    @(posedge clk); #1 check("lat_pulse_lo", bus.dout, 1'b0);
    @(negedge clk) bus.d = 1'b0;
    @(posedge clk); #1 check("lat_no_2cycle", bus.dout, 1'b0);

    // Slow toggle every 173 ns: dout follows at the first rising edge.
    @(negedge clk);
    start_t = $time;
    for (int i = 1; i <= 4; i++) begin
      target_t = start_t + 173 * i;
      #(target_t - $time);
      bus.d = ~bus.d;
      #1 check("slow_hold_old", bus.dout, ~bus.d);
      @(posedge clk);
      #1 check("slow_first_edge", bus.dout, bus.d);
    end

    // Async reset mid-stream while dout = 1.
    @(negedge clk) bus.d = 1'b1;
    @(posedge clk); #1 check("mid_pre_reset", bus.dout, 1'b1);
    #4 reset = 1'b0;
    #1 check("mid_async_clear", bus.dout, 1'b0);
    @(posedge clk); #1 check("mid_hold_1", bus.dout, 1'b0);
    @(posedge clk); #1 check("mid_hold_2", bus.dout, 1'b0);
    #4 reset = 1'b1;
    #1 check("mid_release", bus.dout, 1'b0);
    @(posedge clk); #1 check("mid_first_edge", bus.dout, 1'b1);

    // Random equivalence against a single D-flop with async clear.
    model_q = bus.dout === 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      bus.d = 1'($urandom_range(0, 1));
      if (i == 75) begin
        reset   = 1'b0;
        model_q = 1'b0;
        #1 check("rand_async_clear", bus.dout, 1'b0);
      end
      if (i == 78) reset = 1'b1;
      @(posedge clk);
      if (reset) model_q = bus.d;
      #1 check("rand_equiv", bus.dout, model_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bad_shift_reg

`default_nettype wire

// File: doc/bad_shift_reg.md
# bad_shift_reg

Single-bit serial register block that captures the behaviour of a two-stage shift register written with sequential-order (blocking-style) updates. Because both stages update in order within one clock event, the chain collapses: `dout` equals `d` delayed by exactly one clock, not two. It is a reference/demonstration block used alongside the correct two-stage shift register to show the latency difference. It sits directly on a serial data line.

## Interface

- Parameters: none. The width is fixed at 1 bit.
- `clk` (input, 1): rising-edge clock. This is the only clock.
- `reset` (input, 1): asynchronous, active-low reset. The port keeps the codebase name `reset`. Low clears all state immediately.
- `d` (input, 1): serial data in. Sampled on the rising edge of `clk`.
- `dout` (output, 1): serial data out, registered.

## Operation

- Internal stage `q1` and output stage `dout` are both state bits.
- When `reset` is low, asynchronously and independent of `clk`:
  - `q1 = 0` and `dout = 0`.
  - They stay 0 for as long as `reset` is low.
- On each `clk` rising edge while `reset` is high, the update is ordered:
  - `q1` takes `d`.
  - `dout` then takes the new `q1`.
- Net effect: `q1 == dout` at all times after the first edge, and `dout(n+1) = d(n)`.
- The design elaborates to one flip-flop. `q1` may be optimised away. Only `dout` is observable.
- Reset has priority over any clock edge that coincides with it.
- No enable, no load, no parallel outputs.

## Timing

- Latency is 1 clock from `d` sampled at an edge to `dout` valid after that same edge.
  - This is deliberately not 2. The intended two-stage register would give 2.
- Throughput: one bit per clock.
- `dout` changes only on a `clk` rising edge or on `reset` falling.
- Reset assert (`reset` falling), at any time including mid-stream:
  - `dout` goes to 0 within the clock-to-Q delay.
  - Bits in flight are lost.
- Reset release (`reset` rising):
  - The first capture happens at the first rising edge after release.
  - Releasing coincident with an edge is a setup/hold violation. Benches must avoid it.
- `d` must meet setup and hold around the rising edge. There is no internal synchroniser.

## Structure

- One module, about 120 lines including a header and an optional assertion section. The assertion section checks:
  - `dout` equals `d` as sampled at the previous edge.
  - `dout` is 0 while `reset` is low.
- No shared package is needed. If the team wants one, put a reset-level constant (`RST_ACTIVE = 1'b0`) in the common package.
- No sub-modules.
- The correct two-stage register (`good_shift_reg`, non-blocking ordering, latency 2) is a separate sibling block. It is not part of this one.

## Test plan

1. **Reset hold.**
   - Stimulus: `reset = 0` for 123 ns with `d` toggling; 20 ns clock.
   - Required: `dout = 0` throughout.
2. **Single-cycle latency.**
   - Stimulus: `reset = 1`; drive `d = 1` before edge k, `d = 0` before edge k+1.
   - Required: `dout = 1` after edge k and `dout = 0` after edge k+1. `dout` must never show the 2-cycle-delayed value.
3. **Slow toggle.**
   - Stimulus: `d` inverts every 173 ns with a 20 ns clock.
   - Required: each `dout` transition occurs at the first rising edge after the `d` change, i.e. at most 20 ns later.
4. **Async reset mid-stream.**
   - Stimulus: while `dout = 1`, pull `reset` low between edges.
   - Required: `dout = 0` before the next edge and held at 0 while `reset` stays low.
5. **Reset release.**
   - Stimulus: raise `reset` with `d = 1`, 5 ns after an edge.
   - Required: `dout` stays 0 until the next rising edge, then becomes 1.
6. **Equivalence against the collapsed model.**
   - Stimulus: 3000 ns of random `d`.
   - Required: `dout` matches a single D-flop model with the same async active-low clear on every cycle.
